// File: rtl/channel_merge_arb.sv
// K-input merge: per-input FIFOs drained by a round-robin / fixed-priority arbiter into one
// registered output word {src, data}. Optional counters enabled by `define CHANNEL_MERGE_CNT_EN.
module channel_merge_arb #(
   parameter int unsigned N  = 32,
   parameter int unsigned K  = 4,
   parameter int unsigned D  = 4,
   parameter int unsigned NS = (K > 1 ? $clog2(K) : 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [K*N-1:0]  in_d,
   input  logic [K-1:0]    in_v,
   output logic [K-1:0]    in_a,
   output logic [N+NS-1:0] out_d,
   output logic            out_v,
   input  logic            out_a,
   input  logic            mode,
   input  logic            stall,
   input  logic            clr_cnt,
   output logic [K*16-1:0] cnt
);

   localparam int unsigned AW = $clog2(D);

   logic [N-1:0]    mem [K][D];
   logic [AW:0]     wptr_q [K];
   logic [AW:0]     rptr_q [K];
   logic [K-1:0]    full;
   logic [K-1:0]    empty;
   logic [K-1:0]    push;
   logic [K-1:0]    pop;
   logic            ready_q;

   logic [NS-1:0]   ptr_q;
   logic [NS-1:0]   base;
   logic            mode_q;
   logic            mode_edge;
   logic            or_free;
   logic            arb_en;
   logic            found;
   logic [NS-1:0]   grant;
   logic [NS-1:0]   ptr_next;
   logic [N-1:0]    head;

   logic            out_v_q;
   logic [N+NS-1:0] out_d_q;

   // Ready is held low in reset and rises on the first edge after release.
   always_comb begin
      for (int unsigned i = 0; i < K; i++) begin
         empty[i] = (wptr_q[i] == rptr_q[i]);
         full[i]  = (wptr_q[i][AW] != rptr_q[i][AW]) &&
                    (wptr_q[i][AW-1:0] == rptr_q[i][AW-1:0]);
         in_a[i]  = ready_q && !full[i];
         push[i]  = in_v[i] && in_a[i];
      end
   end

   assign mode_edge = (mode != mode_q);
   assign base      = mode_edge ? '0 : ptr_q;
   assign or_free   = !out_v_q || out_a;

   always_comb begin
      int unsigned idx;
      found = 1'b0;
      grant = '0;
      idx   = 0;
      for (int unsigned o = 0; o < K; o++) begin
         idx = mode ? o : (32'(base) + o) % K;
         for (int unsigned i = 0; i < K; i++) begin
            if (!found && (i == idx) && !empty[i]) begin
               found = 1'b1;
               grant = NS'(i);
            end
         end
      end
   end

   assign arb_en   = or_free && !stall && found;
   assign ptr_next = NS'((32'(grant) + 1) % K);

   always_comb begin
      head = '0;
      for (int unsigned i = 0; i < K; i++) begin
         pop[i] = arb_en && (grant == NS'(i));
         if (grant == NS'(i)) begin
            head = mem[i][rptr_q[i][AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < K; i++) begin
         if (push[i]) begin
            mem[i][wptr_q[i][AW-1:0]] <= in_d[i*N +: N];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < K; i++) begin
            wptr_q[i] <= '0;
            rptr_q[i] <= '0;
         end
         ready_q <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < K; i++) begin
            if (push[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
            if (pop[i])  rptr_q[i] <= rptr_q[i] + 1'b1;
         end
         ready_q <= 1'b1;
      end
   end

   // Fixed-priority grants leave ptr alone; any mode change restarts it at 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q   <= '0;
         mode_q  <= 1'b0;
         out_v_q <= 1'b0;
         out_d_q <= '0;
      end else begin
         mode_q <= mode;
         if (arb_en && !mode) begin
            ptr_q <= ptr_next;
         end else if (mode_edge) begin
            ptr_q <= '0;
         end
         if (arb_en) begin
            out_v_q <= 1'b1;
            out_d_q <= {grant, head};
         end else if (out_v_q && out_a) begin
            out_v_q <= 1'b0;
         end
      end
   end

   assign out_v = out_v_q;
   assign out_d = out_d_q;

`ifdef CHANNEL_MERGE_CNT_EN
   logic [15:0] cnt_q [K];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < K; i++) cnt_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < K; i++) begin
            if (clr_cnt) begin
               cnt_q[i] <= '0;
            end else if (push[i] && (cnt_q[i] != 16'hFFFF)) begin
               cnt_q[i] <= cnt_q[i] + 16'd1;
            end
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < K; i++) cnt[i*16 +: 16] = cnt_q[i];
   end
`else
   logic unused_clr_cnt;
   assign unused_clr_cnt = clr_cnt;
   assign cnt = '0;
`endif

endmodule

// File: tb/tb_channel_merge_arb.sv
// Randomised and directed bench for channel_merge_arb against a queue-based reference model.
module tb_channel_merge_arb;

   localparam int N  = 32;
   localparam int K  = 4;
   localparam int D  = 4;
   localparam int NS = 2;

   logic            clk;
   logic            reset;
   logic [K*N-1:0]  in_d;
   logic [K-1:0]    in_v;
   logic [K-1:0]    in_a;
   logic [N+NS-1:0] out_d;
   logic            out_v;
   logic            out_a;
   logic            mode;
   logic            stall;
   logic            clr_cnt;
   logic [K*16-1:0] cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   channel_merge_arb #(.N(N), .K(K), .D(D)) dut (
      .clk     (clk),
      .reset   (reset),
      .in_d    (in_d),
      .in_v    (in_v),
      .in_a    (in_a),
      .out_d   (out_d),
      .out_v   (out_v),
      .out_a   (out_a),
      .mode    (mode),
      .stall   (stall),
      .clr_cnt (clr_cnt),
      .cnt     (cnt)
   );

   // Reference model state
   logic [N-1:0]    mq [K][$];
   bit              m_ready;
   bit              m_ov;
   bit              m_mode_prev;
   logic [N+NS-1:0] m_od;
   int              m_ptr;
   int              m_cnt [K];

   int n_pass   = 0;
   int n_checks = 0;

   logic [K*N-1:0] d;
   logic [K-1:0]   v;
   logic [N-1:0]   sent [$];
   logic [N-1:0]   got  [$];
   int             acc;
   bit             md;

   task automatic check(string tag, logic [63:0] seen, logic [63:0] want);
      n_checks++;
      if (seen === want) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, seen, want, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < K; i++) begin
         mq[i].delete();
         m_cnt[i] = 0;
      end
      m_ready     = 0;
      m_ov        = 0;
      m_od        = '0;
      m_ptr       = 0;
      m_mode_prev = 0;
   endtask

   task automatic check_state(string tag);
      logic [K-1:0]    ea;
      logic [K*16-1:0] ec;
      for (int i = 0; i < K; i++) begin
         ea[i]          = m_ready && (mq[i].size() < D);
         ec[i*16 +: 16] = 16'(m_cnt[i]);
      end
      check({tag, " in_a"},  64'(in_a),  64'(ea));
      check({tag, " out_v"}, 64'(out_v), 64'(m_ov));
      check({tag, " out_d"}, 64'(out_d), 64'(m_od));
      check({tag, " cnt"},   64'(cnt),   64'(ec));
   endtask

   // Drive one cycle, advance the model by one edge, then compare after the edge.
   task automatic step(string tag, logic [K-1:0] sv, logic [K*N-1:0] sd, bit oa, bit st,
                       bit smd, bit clr);
      logic [K-1:0]  ea;
      logic [NS-1:0] gs;
      bit            hit;
      int            g;
      int            b;
      in_v    = sv;
      in_d    = sd;
      out_a   = oa;
      stall   = st;
      mode    = smd;
      clr_cnt = clr;
      for (int i = 0; i < K; i++) ea[i] = m_ready && (mq[i].size() < D);
      b   = (smd != m_mode_prev) ? 0 : m_ptr;
      hit = 0;
      g   = 0;
      if ((!m_ov || oa) && !st) begin
         for (int o = 0; o < K; o++) begin
            int idx;
            idx = smd ? o : (b + o) % K;
            if (!hit && mq[idx].size() > 0) begin
               hit = 1;
               g   = idx;
            end
         end
      end
      if (hit) begin
         gs   = g[NS-1:0];
         m_od = {gs, mq[g].pop_front()};
         m_ov = 1;
      end else if (m_ov && oa) begin
         m_ov = 0;
      end
      if (hit && !smd) m_ptr = (g + 1) % K;
      else if (smd != m_mode_prev) m_ptr = 0;
      for (int i = 0; i < K; i++) begin
         if (sv[i] && ea[i]) mq[i].push_back(sd[i*N +: N]);
`ifdef CHANNEL_MERGE_CNT_EN
         if (clr) m_cnt[i] = 0;
         else if (sv[i] && ea[i] && m_cnt[i] < 65535) m_cnt[i]++;
`endif
      end
      m_mode_prev = smd;
      m_ready     = 1;
      @(posedge clk);
      #1;
      check_state(tag);
   endtask

   task automatic do_reset(string tag);
      in_v    = 4'($urandom());
      out_a   = 1'b0;
      stall   = 1'b0;
      clr_cnt = 1'b0;
      #2 reset = 1'b0;
      #1;
      model_reset();
      check_state({tag, " during"});
      @(posedge clk);
      #1;
      check_state({tag, " held"});
      reset = 1'b1;
      step({tag, " release"}, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic rand_data();
      for (int i = 0; i < K; i++) d[i*N +: N] = $urandom();
   endtask

   initial begin
      reset   = 1'b0;
      in_v    = '0;
      in_d    = '0;
      out_a   = 1'b0;
      mode    = 1'b0;
      stall   = 1'b0;
      clr_cnt = 1'b0;
      model_reset();

      // Single word from input 2
      do_reset("rst0");
      d = '0;
      d[2*N +: N] = 32'hDEADBEEF;
      step("sw.t", 4'b0100, d, 1, 0, 0, 0);
      check("sw.v_t", 64'(out_v), 64'd0);
      step("sw.t1", '0, '0, 1, 0, 0, 0);
      check("sw.v_t1", 64'(out_v), 64'd1);
      check("sw.d_t1", 64'(out_d), 64'({2'd2, 32'hDEADBEEF}));
      step("sw.t2", '0, '0, 1, 0, 0, 0);
      check("sw.v_t2", 64'(out_v), 64'd0);

      // Round-robin fairness
      do_reset("rst1");
      for (int c = 0; c < 16; c++) begin
         for (int i = 0; i < K; i++) d[i*N +: N] = {8'(i), 24'(c)};
         step("rr", 4'hF, d, 1, 0, 0, 0);
         if (c >= 1) begin
            check("rr.v", 64'(out_v), 64'd1);
            check("rr.src", 64'(out_d[N +: NS]), 64'((c - 1) % K));
         end
      end

      // Fixed priority: 0 beats 3 until input 0 stops
      do_reset("rst2");
      for (int c = 0; c < 8; c++) begin
         rand_data();
         step("fp", 4'b1001, d, 1, 0, 1, 0);
         if (c >= 1) check("fp.src0", 64'(out_d[N +: NS]), 64'd0);
      end
      rand_data();
      step("fp.drop", 4'b1000, d, 1, 0, 1, 0);
      step("fp.next", 4'b1000, d, 1, 0, 1, 0);
      check("fp.src3", 64'(out_d[N +: NS]), 64'd3);

      // Backpressure: 4 in the FIFO + 1 in the output register
      do_reset("rst3");
      acc = 0;
      sent.delete();
      got.delete();
      for (int c = 0; c < 10; c++) begin
         rand_data();
         if (in_a[1]) begin
            acc++;
            sent.push_back(d[N +: N]);
         end
         step("bp.fill", 4'b0010, d, 0, 0, 0, 0);
      end
      check("bp.acc", 64'(acc), 64'd5);
      check("bp.a1", 64'(in_a[1]), 64'd0);
      for (int c = 0; c < 8; c++) begin
         if (out_v) got.push_back(out_d[N-1:0]);
         step("bp.drain", '0, '0, 1, 0, 0, 0);
      end
      check("bp.cnt", 64'(got.size()), 64'(sent.size()));
      for (int k = 0; k < 5 && k < got.size() && k < sent.size(); k++)
         check("bp.word", 64'(got[k]), 64'(sent[k]));

      // Stall: held word delivered, nothing new granted, then reset mid-stream
      for (int c = 0; c < 3; c++) begin
         rand_data();
         step("st.fill", 4'b0010, d, 0, 0, 0, 0);
      end
      step("st.deliver", '0, '0, 1, 1, 0, 0);
      check("st.v", 64'(out_v), 64'd0);
      rand_data();
      step("st.hold", 4'b0100, d, 1, 1, 0, 0);
      check("st.v2", 64'(out_v), 64'd0);
      do_reset("st.rst");
      check("st.a_after", 64'(in_a), 64'hF);
      step("st.after", '0, '0, 1, 0, 0, 0);
      check("st.v_after", 64'(out_v), 64'd0);

      // Randomised traffic with mode flips, stalls, clears and occasional resets
      do_reset("rst4");
      md = 0;
      for (int c = 0; c < 3000; c++) begin
         rand_data();
         v = 4'($urandom());
         if ($urandom_range(63) == 0) md = !md;
         if ($urandom_range(499) == 0) do_reset("rnd.rst");
         step("rnd", v, d, ($urandom_range(3) != 0), ($urandom_range(9) == 0), md,
              ($urandom_range(49) == 0));
      end

`ifdef CHANNEL_MERGE_CNT_EN
      do_reset("rst5");
      for (int c = 0; c < 70000; c++) begin
         rand_data();
         step("cnt.run", 4'b0001, d, 1, 0, 0, 0);
      end
      check("cnt.sat", 64'(cnt[15:0]), 64'hFFFF);
      rand_data();
      step("cnt.clr", 4'b0001, d, 1, 0, 0, 1);
      check("cnt.clr0", 64'(cnt[15:0]), 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/channel_merge_arb.md
# channel_merge_arb

Parametrised K-input merge stage for the Channel datapaths in the core: it generalises the fixed two-input tag merge and the three-input PC packer into one arbitrated block. Each input gets its own FIFO; an arbiter with a runtime-selectable mode (round-robin or fixed priority) drains them into a single registered output Channel. Each output word carries the index of its source input. The block can replace any N-way merge point, including the PC-out and BD-out merges, and honours a downstream stall.

## Interface

Parameters:
- N = 32: data width per input word.
- K = 4: number of input channels; 1 to 16.
- D = 4: per-input FIFO depth; power of two, at least 2.
- NS = (K > 1 ? $clog2(K) : 1): source-index width (derived; do not override).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- in  ChannelArray #(N, K)  K × (d[N], v, a)  input channels; in.a is an output of this block.
- out  Channel #(N+NS)  d[N+NS], v, a  merged output; d = {src, data}; out.a is an input to this block.
- mode  input  1  arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- stall  input  1  when 1, no new grants are issued.
- clr_cnt  input  1  synchronous clear of the statistics counters.
- cnt  output  K×16  per-input accepted-word counters (see Configuration).

## Operation

- Transfer rule: a word moves on a rising edge when v and a are both 1 on that channel.
- Inputs:
  - in[i].a = !full[i]. It is derived from registered occupancy only and never depends on in[i].v.
  - There is no bypass: a full FIFO deasserts a even if it pops in the same cycle.
- Output register (OR): one entry. It loads when it is empty, or when it is being consumed in the same cycle (out.v && out.a). This sustains 1 word/cycle.
- Arbitration happens each cycle when OR can load, stall = 0, and at least one FIFO is non-empty:
  - mode 0: search starts at index ptr, then ptr+1, … modulo K. The first non-empty FIFO wins. On a grant to g, ptr ← (g+1) mod K.
  - mode 1: the lowest-index non-empty FIFO wins. ptr is not updated.
  - The winner's FIFO pops; OR ← {g[NS-1:0], head[g]}.
- Mode change: takes effect at the next arbitration. ptr ← 0 on any mode edge.
- Stall: OR keeps its contents and out.v stays as is. A word already in OR may still be taken downstream. FIFOs keep accepting words until full.
- Reset (asserted at any time, including mid-transfer):
  - All FIFOs are emptied and ptr = 0.
  - out.v = 0, out.d = 0, all in[i].a = 0 while reset is asserted. in[i].a = 1 from the first edge after deassertion.
  - cnt = 0.
  - Words held at reset are dropped.

## Timing

- Latency with an empty pipeline: a word accepted at edge t is written into its FIFO at t. It is granted and loaded into OR at edge t+1, so out.v is high after t+1.
- Throughput: 1 word/cycle total across all inputs. Per input it is 1/(number of active inputs) in mode 0.
- out.d and out.v come straight from registers; there is no combinational path from in.* to out.*.
- out.a affects only OR load enable and the FIFO pop; it has no combinational path to in.a.
- FIFO full boundary: occupancy D ⇒ in.a = 0. A simultaneous pop at occupancy D raises in.a on the following cycle.
- FIFO empty boundary: occupancy 0 ⇒ the FIFO is not eligible, even if in.v = 1 in the same cycle.
- Pointers wrap modulo D (FIFO) and modulo K (ptr). When K = 1, src is always 0.

## Configuration

- CHANNEL_MERGE_CNT_EN defined:
  - cnt[i] increments on every accepted in[i] transfer and saturates at 16'hFFFF.
  - clr_cnt = 1 sets all counters to 0 and takes priority over a same-cycle increment.
- CHANNEL_MERGE_CNT_EN undefined: cnt is tied to 0, clr_cnt is ignored, and no counter logic is synthesised.

## Test plan

- Single word: K=4, N=32. in[2] sends 32'hDEADBEEF at edge t with out.a=1. Required: out.v=1 after t+1 with out.d = {2'd2, 32'hDEADBEEF}, and out.v=0 at t+2.
- Round-robin fairness: mode=0, all four inputs stream continuously, out.a=1. Required: src sequence 0,1,2,3,0,1,… at 1 word/cycle, with no gaps after the first word.
- Fixed priority: mode=1, inputs 0 and 3 both stream. Required: only src=0 appears until in[0].v drops; src=3 is then served on the next cycle.
- Backpressure / full: out.a=0 and D=4, in[1] streams. Required: OR holds 1 word and in[1].a falls after 5 accepted words (4 in the FIFO + 1 in OR). Raising out.a drains all 5 in order with no loss or duplication.
- Stall and reset: OR is full and stall=1. Required: OR is delivered on out.a and no new word appears. Then reset=0 mid-stream ⇒ out.v=0, in.a=0, and after release in.a=1 with FIFOs empty.
- Counters (CHANNEL_MERGE_CNT_EN): 70000 transfers on in[0] ⇒ cnt[0]=16'hFFFF. clr_cnt together with a transfer in the same cycle ⇒ cnt[0]=0.
